// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : whack_pkg
// Description : Shared screen geometry, colour key and blit state encoding
//               for the sprite blitter.
// Revision    : 1.0 - initial release
// ============================================================================
package whack_pkg;

    localparam int          SCR_W    = 160;
    localparam int          SCR_H    = 120;
    localparam int          COLOUR_W = 12;
    localparam logic [11:0] TRANSP   = 12'hF0F;

    // Screen coordinates are 8 bits; origin+offset sums need one extra bit.
    localparam int          XY_W     = 8;
    localparam int          PXY_W    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/blit_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : blit_delay_line
// Description : Fixed-depth shift register that delays {valid, px, py} so it
//               lines up with the ROM read data.
// Revision    : 1.0 - initial release
// ============================================================================
module blit_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [DEPTH*WIDTH-1:0] r_shift;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset) r_shift <= '0;
                else       r_shift <= i_din;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (reset) r_shift <= '0;
                else       r_shift <= {r_shift[(DEPTH-1)*WIDTH-1:0], i_din};
            end
        end
    endgenerate

    assign o_dout = r_shift[DEPTH*WIDTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_blitter
// Description : Walks a W x H image ROM and emits one clipped, colour-keyed
//               pixel per clock towards the VGA adapter.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter
    import whack_pkg::*;
#(
    parameter int                  IMG_W    = 160,
    parameter int                  IMG_H    = 120,
    parameter int                  SCR_W    = whack_pkg::SCR_W,
    parameter int                  SCR_H    = whack_pkg::SCR_H,
    parameter int                  ADDR_W   = 15,
    parameter int                  COLOUR_W = whack_pkg::COLOUR_W,
    parameter int                  ROM_LAT  = 1,
    parameter logic [COLOUR_W-1:0] TRANSP   = whack_pkg::TRANSP,
    parameter bit                  USE_KEY  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          org_x,
    input  logic [7:0]          org_y,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [7:0]          x,
    output logic [7:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int c_col_w = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_row_w = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_dw    = 1 + 2 * PXY_W;

    blit_state_t         r_state, w_state_next;
    logic [c_col_w-1:0]  r_col;
    logic [c_row_w-1:0]  r_row;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [XY_W-1:0]     r_org_x, r_org_y;
    logic [1:0]          r_drain;
    logic [XY_W-1:0]     r_x, r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;

    logic                w_last_col, w_last_row, w_last_px;
    logic [PXY_W-1:0]    w_px, w_py;
    logic [c_dw-1:0]     w_din, w_dout;
    logic                w_d_valid;
    logic [PXY_W-1:0]    w_d_px, w_d_py;
    logic                w_plot_next;

    assign w_last_col = (r_col == c_col_w'(IMG_W - 1));
    assign w_last_row = (r_row == c_row_w'(IMG_H - 1));
    assign w_last_px  = w_last_col && w_last_row;

    assign w_px  = PXY_W'(r_org_x) + PXY_W'(r_col);
    assign w_py  = PXY_W'(r_org_y) + PXY_W'(r_row);
    assign w_din = {(r_state == FETCH), w_px, w_py};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = FETCH;
            FETCH:   if (w_last_px) w_state_next = DRAIN;
            DRAIN:   if (r_drain == 2'(ROM_LAT)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Row-major scan: the address advances by one per slot, no multiply needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_rom_addr <= '0;
            r_org_x    <= '0;
            r_org_y    <= '0;
            r_drain    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_org_x    <= org_x;
                        r_org_y    <= org_y;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_rom_addr <= '0;
                    end
                end
                FETCH: begin
                    r_drain <= '0;
                    if (!w_last_px) r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    if (w_last_col) begin
                        r_col <= '0;
                        if (!w_last_row) r_row <= r_row + c_row_w'(1);
                    end else begin
                        r_col <= r_col + c_col_w'(1);
                    end
                end
                DRAIN:   r_drain <= r_drain + 2'd1;
                default: ;
            endcase
        end
    end

    blit_delay_line #(
        .DEPTH (ROM_LAT),
        .WIDTH (c_dw)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .i_din  (w_din),
        .o_dout (w_dout)
    );

    assign w_d_valid = w_dout[2*PXY_W];
    assign w_d_px    = w_dout[2*PXY_W-1 -: PXY_W];
    assign w_d_py    = w_dout[PXY_W-1:0];

    // Clipped and keyed slots still occupy their cycle; only the strobe drops.
    assign w_plot_next = w_d_valid
                      && (w_d_px < PXY_W'(SCR_W))
                      && (w_d_py < PXY_W'(SCR_H))
                      && !(USE_KEY && (rom_q == TRANSP));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_plot <= w_plot_next;
            if (w_d_valid) begin
                r_x      <= w_d_px[XY_W-1:0];
                r_y      <= w_d_py[XY_W-1:0];
                r_colour <= rom_q;
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign x        = r_x;
    assign y        = r_y;
    assign colour   = r_colour;
    assign plot     = r_plot;
    assign busy     = (r_state == FETCH) || (r_state == DRAIN);
    assign done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_blitter
// Description : Directed self-checking bench; five blitter builds cover full
//               backgrounds, clipped and keyed sprites and a two-cycle ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sprite_blitter;

    localparam int N = 5;

    // Instance 0: 160x120 lat1 nokey, 1: 8x8 key, 2: 4x4 key, 3: 4x4 nokey, 4: 160x120 lat2
    function automatic int p_w(input int i);
        case (i)
            1:       return 8;
            2, 3:    return 4;
            default: return 160;
        endcase
    endfunction

    function automatic int p_h(input int i);
        case (i)
            1:       return 8;
            2, 3:    return 4;
            default: return 120;
        endcase
    endfunction

    function automatic int p_lat(input int i);
        return (i == 4) ? 2 : 1;
    endfunction

    function automatic bit p_key(input int i);
        return (i == 1 || i == 2);
    endfunction

    function automatic int ox(input int i);
        case (i)
            1:       return 156;
            2, 3:    return 10;
            default: return 0;
        endcase
    endfunction

    function automatic int oy(input int i);
        case (i)
            1:       return 116;
            2, 3:    return 20;
            default: return 0;
        endcase
    endfunction

    function automatic logic [11:0] rom_f(input int i, input logic [14:0] a);
        case (i)
            1:       return 12'h0A0;
            2, 3:    return a[0] ? 12'h123 : 12'hF0F;
            default: return a[11:0];
        endcase
    endfunction

    function automatic logic [11:0] exp_colour(input int i, input logic [7:0] xx, input logic [7:0] yy);
        int a;
        a = (int'(yy) - oy(i)) * p_w(i) + (int'(xx) - ox(i));
        return rom_f(i, 15'(a));
    endfunction

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         start_v;
    logic [N-1:0]         plot_v, busy_v, done_v;
    logic [N-1:0][7:0]    ox_v, oy_v, x_v, y_v;
    logic [N-1:0][14:0]   addr_v;
    logic [N-1:0][11:0]   q_v, colour_v, rq1, rq2;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            assign ox_v[g] = 8'(ox(g));
            assign oy_v[g] = 8'(oy(g));
            assign q_v[g]  = (p_lat(g) == 2) ? rq2[g] : rq1[g];

            sprite_blitter #(
                .IMG_W    (p_w(g)),
                .IMG_H    (p_h(g)),
                .SCR_W    (160),
                .SCR_H    (120),
                .ADDR_W   (15),
                .COLOUR_W (12),
                .ROM_LAT  (p_lat(g)),
                .TRANSP   (12'hF0F),
                .USE_KEY  (p_key(g))
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .start    (start_v[g]),
                .org_x    (ox_v[g]),
                .org_y    (oy_v[g]),
                .rom_addr (addr_v[g]),
                .rom_q    (q_v[g]),
                .x        (x_v[g]),
                .y        (y_v[g]),
                .colour   (colour_v[g]),
                .plot     (plot_v[g]),
                .busy     (busy_v[g]),
                .done     (done_v[g])
            );
        end
    endgenerate

    // Synchronous ROM models: one and two register stages.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            rq1[i] <= rom_f(i, addr_v[i]);
            rq2[i] <= rq1[i];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          plot_cnt[N], done_cnt[N], bad_cnt[N];
    int          first_cyc[N], last_cyc[N], done_cyc[N], arm[N];
    logic [7:0]  first_x[N], first_y[N], last_x[N], last_y[N];
    logic [11:0] first_c[N], last_c[N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (plot_v[i] === 1'b1) begin
                plot_cnt[i] <= plot_cnt[i] + 1;
                if (first_cyc[i] < arm[i]) begin
                    first_cyc[i] <= cyc;
                    first_x[i]   <= x_v[i];
                    first_y[i]   <= y_v[i];
                    first_c[i]   <= colour_v[i];
                end
                last_cyc[i] <= cyc;
                last_x[i]   <= x_v[i];
                last_y[i]   <= y_v[i];
                last_c[i]   <= colour_v[i];
                if (colour_v[i] !== exp_colour(i, x_v[i], y_v[i]))
                    bad_cnt[i] <= bad_cnt[i] + 1;
            end
            if (done_v[i] === 1'b1) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_cyc[i] <= cyc;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic do_start(input int i, output int t0);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int base, input int limit);
        for (int k = 0; k < limit && done_cnt[i] == base; k++) @(posedge clk);
    endtask

    int t0, t4, p0, d0, b0, p4, d4, b4;

    initial begin
        reset   = 1'b1;
        start_v = '0;
        for (int i = 0; i < N; i++) arm[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_plot", 32'(plot_v), 0);
        chk("rst_busy", 32'(busy_v), 0);
        chk("rst_done", 32'(done_v), 0);
        chk("rst_addr", 32'(addr_v[0]), 0);
        chk("rst_x", 32'(x_v[0]), 0);
        @(negedge clk);
        reset = 1'b0;

        // Full background (lat 1) alongside the lat-2 build of the same image
        p0 = plot_cnt[0]; d0 = done_cnt[0]; b0 = bad_cnt[0];
        p4 = plot_cnt[4]; d4 = done_cnt[4]; b4 = bad_cnt[4];
        do_start(4, t4); arm[4] = t4;
        do_start(0, t0); arm[0] = t0;
        chk("t1_busy_c1", 32'(busy_v[0]), 1);
        wait_done(0, d0, 20000);
        wait_done(4, d4, 20000);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_plots", plot_cnt[0] - p0, 19200);
        chk("t1_first_cyc", first_cyc[0] - t0 + 1, 3);
        chk("t1_first_pix", {first_x[0], first_y[0], 4'h0, first_c[0]}, 32'h0);
        chk("t1_last_cyc", last_cyc[0] - t0 + 1, 19202);
        chk("t1_last_pix", {last_x[0], last_y[0], 4'h0, last_c[0]}, {8'd159, 8'd119, 16'h0AFF});
        chk("t1_done_cyc", done_cyc[0] - t0 + 1, 19203);
        chk("t1_done_cnt", done_cnt[0] - d0, 1);
        chk("t1_colour_bad", bad_cnt[0] - b0, 0);
        chk("t1_busy_end", 32'(busy_v[0]), 0);
        chk("t6_plots", plot_cnt[4] - p4, 19200);
        chk("t6_first_cyc", first_cyc[4] - t4 + 1, 4);
        chk("t6_done_cyc", done_cyc[4] - t4 + 1, 19204);
        chk("t6_colour_bad", bad_cnt[4] - b4, 0);

        // 8x8 sprite clipped at the bottom-right corner; start on the done cycle
        do_start(1, t0); arm[1] = t0;
        repeat (67) @(negedge clk);
        chk("t2_done_now", 32'(done_v[1]), 1);
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        chk("t2_start_on_done", 32'(busy_v[1]), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_still_idle", 32'(busy_v[1]), 0);
        chk("t2_plots", plot_cnt[1], 16);
        chk("t2_done_cyc", done_cyc[1] - t0 + 1, 67);
        chk("t2_done_cnt", done_cnt[1], 1);
        chk("t2_first_xy", {first_x[1], first_y[1]}, {8'd156, 8'd116});
        chk("t2_last_xy", {last_x[1], last_y[1]}, {8'd159, 8'd119});
        chk("t2_colour_bad", bad_cnt[1], 0);

        // 4x4 sprite with alternating key colour, keyed and unkeyed builds
        do_start(2, t0); arm[2] = t0;
        wait_done(2, 0, 100);
        do_start(3, t4); arm[3] = t4;
        wait_done(3, 0, 100);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_key_plots", plot_cnt[2], 8);
        chk("t3_key_colour", 32'(last_c[2]), 32'h123);
        chk("t3_key_bad", bad_cnt[2], 0);
        chk("t3_nokey_plots", plot_cnt[3], 16);
        chk("t3_nokey_bad", bad_cnt[3], 0);

        // Start pulsed mid-blit must be dropped
        p0 = plot_cnt[0]; d0 = done_cnt[0]; b0 = bad_cnt[0];
        do_start(0, t0); arm[0] = t0;
        repeat (10) @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        chk("t4_busy", 32'(busy_v[0]), 1);
        wait_done(0, d0, 20000);
        repeat (30) @(posedge clk);
        #1;
        chk("t4_plots", plot_cnt[0] - p0, 19200);
        chk("t4_done_cnt", done_cnt[0] - d0, 1);
        chk("t4_done_cyc", done_cyc[0] - t0 + 1, 19203);
        chk("t4_colour_bad", bad_cnt[0] - b0, 0);

        // Reset at slot 50 aborts the blit
        p0 = plot_cnt[0]; d0 = done_cnt[0];
        do_start(0, t0); arm[0] = t0;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_plot", 32'(plot_v[0]), 0);
        chk("t5_busy", 32'(busy_v[0]), 0);
        chk("t5_done", 32'(done_v[0]), 0);
        chk("t5_plots_before", plot_cnt[0] - p0, 48);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt[0] - d0, 0);
        p0 = plot_cnt[0]; d0 = done_cnt[0]; b0 = bad_cnt[0];
        do_start(0, t0); arm[0] = t0;
        wait_done(0, d0, 20000);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_fresh_plots", plot_cnt[0] - p0, 19200);
        chk("t5_fresh_first", first_cyc[0] - t0 + 1, 3);
        chk("t5_fresh_done", done_cnt[0] - d0, 1);
        chk("t5_fresh_bad", bad_cnt[0] - b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
